// File: rtl/memory_arbiter_router_pkg.sv
// Shared constants for the GBC memory interconnect: arbitration modes,
// the default region map, and small sizing helpers.
package memory_arbiter_router_pkg;

  // Arbitration modes
  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Default slave ordering (slave index = enum value)
  typedef enum logic [2:0] {
    SlvRom  = 3'd0,
    SlvVram = 3'd1,
    SlvEram = 3'd2,
    SlvWram = 3'd3,
    SlvOam  = 3'd4,
    SlvHram = 3'd5
  } slave_e;

  // Region windows, [LO, HI). Echo RAM and the FEA0-FEFF hole stay unmapped.
  localparam logic [15:0] ROM_LO  = 16'h0000;
  localparam logic [15:0] ROM_HI  = 16'h8000;
  localparam logic [15:0] VRAM_LO = 16'h8000;
  localparam logic [15:0] VRAM_HI = 16'hA000;
  localparam logic [15:0] ERAM_LO = 16'hA000;
  localparam logic [15:0] ERAM_HI = 16'hC000;
  localparam logic [15:0] WRAM_LO = 16'hC000;
  localparam logic [15:0] WRAM_HI = 16'hE000;
  localparam logic [15:0] OAM_LO  = 16'hFE00;
  localparam logic [15:0] OAM_HI  = 16'hFEA0;
  localparam logic [15:0] HRAM_LO = 16'hFF00;
  localparam logic [15:0] HRAM_HI = 16'hFFFF;

  // Packed window vectors, slice s (LSB first) belongs to slave s
  localparam logic [95:0] DEF_SLAVE_LO = {HRAM_LO, OAM_LO, WRAM_LO, ERAM_LO, VRAM_LO, ROM_LO};
  localparam logic [95:0] DEF_SLAVE_HI = {HRAM_HI, OAM_HI, WRAM_HI, ERAM_HI, VRAM_HI, ROM_HI};

  // Index width that stays legal for a single-entry range
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_router_mem_slave_arbiter.sv
// Per-slave arbiter: one-hot grant from a request vector, fixed priority or
// round-robin with a registered pointer.
module memory_arbiter_router_mem_slave_arbiter
  import memory_arbiter_router_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ARB_MODE    = ARB_FIXED
) (
  input  logic                   I_CLK,
  input  logic                   I_RESET_L,
  input  logic [NUM_MASTERS-1:0] I_REQ,
  output logic [NUM_MASTERS-1:0] O_GNT
);

  localparam int unsigned PTR_W = idx_w(NUM_MASTERS);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Pick the first requester at or after the pointer (pointer is 0 in fixed mode)
  always_comb begin
    int unsigned idx;
    logic        found;
    O_GNT = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = (ARB_MODE == ARB_RR) ? (32'(ptr_q) + i) : i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && I_REQ[PTR_W'(idx)]) begin
        found              = 1'b1;
        O_GNT[PTR_W'(idx)] = 1'b1;
        if (ARB_MODE == ARB_RR) begin
          ptr_d = (idx + 1 == NUM_MASTERS) ? '0 : PTR_W'(idx + 1);
        end
      end
    end
  end

  // Round-robin pointer register
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

endmodule

// File: rtl/memory_arbiter_router.sv
// N-master / M-slave memory interconnect: address decode, per-slave
// arbitration, pipelined read return, and sticky error reporting.
module memory_arbiter_router
  import memory_arbiter_router_pkg::*;
#(
  parameter int unsigned NUM_MASTERS  = 4,
  parameter int unsigned NUM_SLAVES   = 6,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ARB_MODE     = ARB_FIXED,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_LO = DEF_SLAVE_LO,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_HI = DEF_SLAVE_HI,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                          I_CLK,
  input  logic                          I_RESET_L,
  input  logic [NUM_MASTERS*ADDR_W-1:0] I_M_ADDR,
  input  logic [NUM_MASTERS*DATA_W-1:0] I_M_WDATA,
  input  logic [NUM_MASTERS-1:0]        I_M_WE_L,
  input  logic [NUM_MASTERS-1:0]        I_M_RE_L,
  output logic [NUM_MASTERS-1:0]        O_M_GNT,
  output logic [NUM_MASTERS*DATA_W-1:0] O_M_RDATA,
  output logic [NUM_MASTERS-1:0]        O_M_RVALID,
  output logic [NUM_SLAVES*ADDR_W-1:0]  O_S_ADDR,
  output logic [NUM_SLAVES*DATA_W-1:0]  O_S_WDATA,
  output logic [NUM_SLAVES-1:0]         O_S_WE_L,
  output logic [NUM_SLAVES-1:0]         O_S_RE_L,
  input  logic [NUM_SLAVES*DATA_W-1:0]  I_S_RDATA,
  input  logic                          I_ERR_CLR,
  output logic [NUM_MASTERS-1:0]        O_UNMAPPED_ERROR,
  output logic                          O_CONFLICT_ERROR,
  output logic [CNT_W-1:0]              O_CONFLICT_COUNT
);

  localparam int unsigned SIDX_W = idx_w(NUM_SLAVES);
  localparam int unsigned LAST   = READ_LATENCY - 1;

  logic [NUM_MASTERS-1:0] m_req, m_wr, m_rd, m_hit, m_unmapped, m_rd_acc;
  logic [SIDX_W-1:0]      m_sel [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] s_req [NUM_SLAVES];
  logic [NUM_MASTERS-1:0] s_gnt [NUM_SLAVES];

  logic                   tag_v_q [NUM_MASTERS][READ_LATENCY];
  logic                   tag_u_q [NUM_MASTERS][READ_LATENCY];
  logic [SIDX_W-1:0]      tag_s_q [NUM_MASTERS][READ_LATENCY];

  logic [NUM_MASTERS-1:0] unmapped_q;
  logic                   conflict_q, conflict_now;
  logic [CNT_W-1:0]       count_q, count_d;

  // Request classification and address decode; lowest matching slave wins
  always_comb begin
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      m_wr[m]  = !I_M_WE_L[m];
      m_rd[m]  = I_M_WE_L[m] && !I_M_RE_L[m];
      m_req[m] = m_wr[m] || m_rd[m];
      m_hit[m] = 1'b0;
      m_sel[m] = '0;
      for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
        if (!m_hit[m] &&
            I_M_ADDR[m*ADDR_W +: ADDR_W] >= SLAVE_LO[s*ADDR_W +: ADDR_W] &&
            I_M_ADDR[m*ADDR_W +: ADDR_W] <  SLAVE_HI[s*ADDR_W +: ADDR_W]) begin
          m_hit[m] = 1'b1;
          m_sel[m] = SIDX_W'(s);
        end
      end
      m_unmapped[m] = m_req[m] && !m_hit[m];
    end
  end

  // Per-slave request vectors
  always_comb begin
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      s_req[s] = '0;
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
        s_req[s][m] = m_req[m] && m_hit[m] && (m_sel[m] == SIDX_W'(s));
      end
    end
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave
    memory_arbiter_router_mem_slave_arbiter #(
      .NUM_MASTERS (NUM_MASTERS),
      .ARB_MODE    (ARB_MODE)
    ) u_arb (
      .I_CLK     (I_CLK),
      .I_RESET_L (I_RESET_L),
      .I_REQ     (s_req[s]),
      .O_GNT     (s_gnt[s])
    );
  end

  // Master grants: idle and unmapped masters are never stalled
  always_comb begin
    O_M_GNT = '1;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
        if (m_req[m] && m_hit[m] && (m_sel[m] == SIDX_W'(s))) O_M_GNT[m] = s_gnt[s][m];
      end
      m_rd_acc[m] = m_rd[m] && O_M_GNT[m];
    end
  end

  // Slave side: the winner drives the port, otherwise idle
  always_comb begin
    O_S_ADDR  = '0;
    O_S_WDATA = '0;
    O_S_WE_L  = '1;
    O_S_RE_L  = '1;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
        if (s_gnt[s][m]) begin
          O_S_ADDR[s*ADDR_W +: ADDR_W]  = I_M_ADDR[m*ADDR_W +: ADDR_W];
          O_S_WDATA[s*DATA_W +: DATA_W] = I_M_WDATA[m*DATA_W +: DATA_W];
          O_S_WE_L[s]                   = !m_wr[m];
          O_S_RE_L[s]                   = m_wr[m];
        end
      end
    end
  end

  // Read tag pipelines; reset flushes in-flight reads so they never return
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
        for (int unsigned k = 0; k < READ_LATENCY; k++) begin
          tag_v_q[m][k] <= 1'b0;
          tag_u_q[m][k] <= 1'b0;
          tag_s_q[m][k] <= '0;
        end
      end
    end else begin
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
        tag_v_q[m][0] <= m_rd_acc[m];
        tag_u_q[m][0] <= !m_hit[m];
        tag_s_q[m][0] <= m_sel[m];
        for (int unsigned k = 1; k < READ_LATENCY; k++) begin
          tag_v_q[m][k] <= tag_v_q[m][k-1];
          tag_u_q[m][k] <= tag_u_q[m][k-1];
          tag_s_q[m][k] <= tag_s_q[m][k-1];
        end
      end
    end
  end

  // Read return: slave data at the pipe tail, all-ones for unmapped reads
  always_comb begin
    O_M_RVALID = '0;
    O_M_RDATA  = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      if (tag_v_q[m][LAST]) begin
        O_M_RVALID[m] = 1'b1;
        if (tag_u_q[m][LAST]) begin
          O_M_RDATA[m*DATA_W +: DATA_W] = '1;
        end else begin
          for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            if (tag_s_q[m][LAST] == SIDX_W'(s)) begin
              O_M_RDATA[m*DATA_W +: DATA_W] = I_S_RDATA[s*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
  end

  // Conflict detect (>=2 requesters on a slave) and counter next state;
  // a new conflict beats a coincident clear
  always_comb begin
    conflict_now = 1'b0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      if ((s_req[s] & (s_req[s] - NUM_MASTERS'(1))) != '0) conflict_now = 1'b1;
    end
    count_d = I_ERR_CLR ? '0 : count_q;
    if (conflict_now && (count_d != '1)) count_d = count_d + CNT_W'(1);
  end

  // Sticky error flags and saturating conflict counter
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      unmapped_q <= '0;
      conflict_q <= 1'b0;
      count_q    <= '0;
    end else begin
      unmapped_q <= (I_ERR_CLR ? '0 : unmapped_q) | m_unmapped;
      conflict_q <= (I_ERR_CLR ? 1'b0 : conflict_q) | conflict_now;
      count_q    <= count_d;
    end
  end

  assign O_UNMAPPED_ERROR = unmapped_q;
  assign O_CONFLICT_ERROR = conflict_q;
  assign O_CONFLICT_COUNT = count_q;

endmodule

// File: tb/tb_memory_arbiter_router.sv
// Directed bench: a fixed-priority/L=1 and a round-robin/L=3 instance share
// the same stimulus; each step compares against hand-computed values.
module tb_memory_arbiter_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_we_l, m_re_l;
  logic [47:0] s_rdata;
  logic        err_clr;

  logic [3:0]  fx_gnt, fx_rvalid, fx_unm, rr_gnt, rr_rvalid, rr_unm;
  logic [31:0] fx_rdata, rr_rdata;
  logic [95:0] fx_s_addr, rr_s_addr;
  logic [47:0] fx_s_wdata, rr_s_wdata;
  logic [5:0]  fx_s_we_l, fx_s_re_l, rr_s_we_l, rr_s_re_l;
  logic        fx_cerr, rr_cerr;
  logic [7:0]  fx_ccnt, rr_ccnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  memory_arbiter_router #(.READ_LATENCY(1), .ARB_MODE(0)) dut_fx (
    .I_CLK(clk), .I_RESET_L(rst_n), .I_M_ADDR(m_addr), .I_M_WDATA(m_wdata),
    .I_M_WE_L(m_we_l), .I_M_RE_L(m_re_l), .O_M_GNT(fx_gnt), .O_M_RDATA(fx_rdata),
    .O_M_RVALID(fx_rvalid), .O_S_ADDR(fx_s_addr), .O_S_WDATA(fx_s_wdata),
    .O_S_WE_L(fx_s_we_l), .O_S_RE_L(fx_s_re_l), .I_S_RDATA(s_rdata), .I_ERR_CLR(err_clr),
    .O_UNMAPPED_ERROR(fx_unm), .O_CONFLICT_ERROR(fx_cerr), .O_CONFLICT_COUNT(fx_ccnt)
  );

  memory_arbiter_router #(.READ_LATENCY(3), .ARB_MODE(1)) dut_rr (
    .I_CLK(clk), .I_RESET_L(rst_n), .I_M_ADDR(m_addr), .I_M_WDATA(m_wdata),
    .I_M_WE_L(m_we_l), .I_M_RE_L(m_re_l), .O_M_GNT(rr_gnt), .O_M_RDATA(rr_rdata),
    .O_M_RVALID(rr_rvalid), .O_S_ADDR(rr_s_addr), .O_S_WDATA(rr_s_wdata),
    .O_S_WE_L(rr_s_we_l), .O_S_RE_L(rr_s_re_l), .I_S_RDATA(s_rdata), .I_ERR_CLR(err_clr),
    .O_UNMAPPED_ERROR(rr_unm), .O_CONFLICT_ERROR(rr_cerr), .O_CONFLICT_COUNT(rr_ccnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_addr  = '0;
    m_wdata = '0;
    m_we_l  = '1;
    m_re_l  = '1;
  endtask

  initial begin
    rst_n   = 1'b1;
    err_clr = 1'b0;
    s_rdata = 48'h00_00_5A_00_00_11;  // WRAM returns 0x5A, ROM returns 0x11
    idle();
    #1 rst_n = 1'b0;
    #2;
    check("rst_rvalid", {28'h0, fx_rvalid}, 32'h0);
    check("rst_rdata",  fx_rdata, 32'h0);
    check("rst_cnt",    {24'h0, fx_ccnt}, 32'h0);
    check("rst_errs",   {27'h0, fx_cerr, fx_unm}, 32'h0);
    check("rst_gnt",    {28'h0, fx_gnt}, 32'hF);
    check("rst_s_re_l", {26'h0, fx_s_re_l}, 32'h3F);
    #19 rst_n = 1'b1;

    // CPU read of WRAM 0xC010
    tick();
    m_addr[15:0] = 16'hC010;
    m_re_l       = 4'b1110;
    #1;
    check("a_s_re_l", {26'h0, fx_s_re_l}, 32'h37);
    check("a_s_addr", {16'h0, fx_s_addr[63:48]}, 32'hC010);
    check("a_gnt",    {28'h0, fx_gnt}, 32'hF);
    check("a_rr_re_l", {26'h0, rr_s_re_l}, 32'h37);
    tick();
    idle();
    #1;
    check("a_fx_rvalid", {28'h0, fx_rvalid}, 32'h1);
    check("a_fx_rdata",  fx_rdata, 32'h5A);
    check("a_rr_early",  {28'h0, rr_rvalid}, 32'h0);
    tick();
    check("a_fx_done",   {28'h0, fx_rvalid}, 32'h0);
    check("a_fx_rdata0", fx_rdata, 32'h0);
    tick();
    check("a_rr_rvalid", {28'h0, rr_rvalid}, 32'h1);
    check("a_rr_rdata",  rr_rdata, 32'h5A);

    // CPU and DMA-rd both read VRAM 0x8000
    m_addr[15:0]  = 16'h8000;
    m_addr[47:32] = 16'h8000;
    m_re_l        = 4'b1010;
    #1;
    check("b_fx_gnt", {28'h0, fx_gnt}, 32'hB);
    check("b_rr_gnt", {28'h0, rr_gnt}, 32'hB);
    check("b_s_addr", {16'h0, fx_s_addr[31:16]}, 32'h8000);
    check("b_s_re_l", {26'h0, fx_s_re_l}, 32'h3D);
    tick();
    m_re_l = 4'b1011;
    #1;
    check("b_dma_gnt", {28'h0, fx_gnt}, 32'hF);
    check("b_cerr",    {31'h0, fx_cerr}, 32'h1);
    check("b_fx_cnt",  {24'h0, fx_ccnt}, 32'h1);
    check("b_rr_cnt",  {24'h0, rr_ccnt}, 32'h1);
    tick();
    idle();
    #1;
    check("b_cnt_hold",   {24'h0, fx_ccnt}, 32'h1);
    check("b_dma_rvalid", {28'h0, fx_rvalid}, 32'h4);

    // Masters 0,1,2 hold requests to OAM until granted
    m_addr[15:0]  = 16'hFE00;
    m_addr[31:16] = 16'hFE00;
    m_addr[47:32] = 16'hFE00;
    m_re_l        = 4'b1000;
    #1;
    check("c_rr_g0", {28'h0, rr_gnt}, 32'h9);
    check("c_fx_g0", {28'h0, fx_gnt}, 32'h9);
    tick();
    m_re_l = 4'b1001;
    #1;
    check("c_rr_g1", {28'h0, rr_gnt}, 32'hB);
    tick();
    m_re_l = 4'b1011;
    #1;
    check("c_rr_g2", {28'h0, rr_gnt}, 32'hF);
    tick();
    m_addr[63:48] = 16'hFE00;
    m_re_l        = 4'b0000;
    #1;
    check("c_rr_ptr3", {28'h0, rr_gnt}, 32'h8);
    check("c_fx_fixed", {28'h0, fx_gnt}, 32'h1);
    check("c_rr_cnt",  {24'h0, rr_ccnt}, 32'h3);
    tick();
    idle();
    #1;
    check("c_rr_cnt4", {24'h0, rr_ccnt}, 32'h4);
    check("c_fx_cnt4", {24'h0, fx_ccnt}, 32'h4);

    // Clear coincident with a conflict: the conflict wins
    err_clr       = 1'b1;
    m_addr[15:0]  = 16'h8000;
    m_addr[31:16] = 16'h8000;
    m_re_l        = 4'b1100;
    tick();
    err_clr = 1'b0;
    m_re_l  = 4'b1101;
    #1;
    check("d_fx_cnt1", {24'h0, fx_ccnt}, 32'h1);
    check("d_fx_cerr", {31'h0, fx_cerr}, 32'h1);
    check("d_rr_cnt1", {24'h0, rr_ccnt}, 32'h1);
    check("d_rr_gnt",  {28'h0, rr_gnt}, 32'hF);
    tick();
    idle();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("d_clr_cnt",  {24'h0, fx_ccnt}, 32'h0);
    check("d_clr_cerr", {31'h0, fx_cerr}, 32'h0);

    // PPU read of unmapped 0xFEA0
    m_addr[31:16] = 16'hFEA0;
    m_re_l        = 4'b1101;
    #1;
    check("u_gnt",    {28'h0, fx_gnt}, 32'hF);
    check("u_s_re_l", {26'h0, fx_s_re_l}, 32'h3F);
    check("u_s_we_l", {26'h0, fx_s_we_l}, 32'h3F);
    tick();
    idle();
    #1;
    check("u_fx_rvalid", {28'h0, fx_rvalid}, 32'h2);
    check("u_fx_rdata",  fx_rdata, 32'h0000FF00);
    check("u_fx_err",    {28'h0, fx_unm}, 32'h2);
    check("u_rr_err",    {28'h0, rr_unm}, 32'h2);
    tick();
    tick();
    check("u_rr_rvalid", {28'h0, rr_rvalid}, 32'h2);
    check("u_rr_rdata",  rr_rdata, 32'h0000FF00);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("u_clr", {28'h0, fx_unm}, 32'h0);

    // CPU write ERAM with both strobes low, DMA-wr write to VRAM top, PPU read ROM top
    m_addr[15:0]   = 16'hA005;
    m_wdata[7:0]   = 8'h3C;
    m_addr[31:16]  = 16'h7FFF;
    m_addr[63:48]  = 16'h9FFF;
    m_wdata[31:24] = 8'hC3;
    m_we_l         = 4'b0110;
    m_re_l         = 4'b1100;
    #1;
    check("e_s_we_l",  {26'h0, fx_s_we_l}, 32'h39);
    check("e_s_re_l",  {26'h0, fx_s_re_l}, 32'h3E);
    check("e_wdata2",  {24'h0, fx_s_wdata[23:16]}, 32'h3C);
    check("e_wdata1",  {24'h0, fx_s_wdata[15:8]}, 32'hC3);
    check("e_addr1",   {16'h0, fx_s_addr[31:16]}, 32'h9FFF);
    check("e_gnt",     {28'h0, fx_gnt}, 32'hF);
    tick();
    idle();
    #1;
    check("e_rvalid",  {28'h0, fx_rvalid}, 32'h2);
    check("e_rdata",   fx_rdata, 32'h00001100);
    check("e_cerr",    {31'h0, fx_cerr}, 32'h0);

    // Saturation: two masters hammer VRAM every cycle
    m_addr[15:0]  = 16'h8000;
    m_addr[31:16] = 16'h8000;
    m_re_l        = 4'b1100;
    repeat (255) tick();
    #1;
    check("f_fx_sat", {24'h0, fx_ccnt}, 32'hFF);
    check("f_rr_sat", {24'h0, rr_ccnt}, 32'hFF);
    repeat (3) tick();
    #1;
    check("f_fx_hold", {24'h0, fx_ccnt}, 32'hFF);
    idle();

    // Back-to-back CPU reads then a reset pulse held across an edge
    tick();
    m_addr[15:0] = 16'hC010;
    m_re_l       = 4'b1110;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    idle();
    #1;
    check("g_rr_in_rst", {28'h0, rr_rvalid}, 32'h0);
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("g_rr_rvalid", {28'h0, rr_rvalid}, 32'h0);
      check("g_fx_rvalid", {28'h0, fx_rvalid}, 32'h0);
    end
    check("g_fx_cnt",  {24'h0, fx_ccnt}, 32'h0);
    check("g_rr_cnt",  {24'h0, rr_ccnt}, 32'h0);
    check("g_rr_errs", {27'h0, rr_cerr, rr_unm}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
